// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl
//   Memory BIST controller running March C- over addresses 0..DEPTH-1 of a
//   single-port array with a registered read path (RD_LAT cycles) and
//   write data that must be presented one cycle ahead of its write command.
//   M0 up(w0), M1 up(r0,w1), M2 up(r1,w0), M3 down(r0,w1), M4 down(r1,w0),
//   M5 up(r0). One memory op per cycle, 10*DEPTH ops per run.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 single-cycle run request (taken in IDLE or DONE)
//   busy / done / fail    run status; fail is valid while done is high
//   fail_count            saturating miscompare count
//   fail_elem/addr/data   element, address and read data of first miscompare
//   mem_write_read        1 = write, 0 = read
//   mem_address, mem_wdata, mem_rdata   memory interface
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [7:0]            fail_count,
  output logic [2:0]            fail_elem,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] D0 = '0;
  localparam logic [DATA_WIDTH-1:0] D1 = '1;
  localparam int DRAIN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(RD_LAT - 1);

  function automatic logic is_two_op(input state_t s);
    return (s == S_M1) || (s == S_M2) || (s == S_M3) || (s == S_M4);
  endfunction

  function automatic logic is_down(input state_t s);
    return (s == S_M3) || (s == S_M4);
  endfunction

  function automatic logic op_is_write(input state_t s, input logic ph);
    return (s == S_M0) || (is_two_op(s) && ph);
  endfunction

  function automatic logic op_is_read(input state_t s, input logic ph);
    return (s == S_M5) || (is_two_op(s) && !ph);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rd_bg(input state_t s);
    return ((s == S_M2) || (s == S_M4)) ? D1 : D0;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] wr_bg(input state_t s);
    return ((s == S_M1) || (s == S_M3)) ? D1 : D0;
  endfunction

  function automatic logic [2:0] elem_idx(input state_t s);
    case (s)
      S_M1:    return 3'd1;
      S_M2:    return 3'd2;
      S_M3:    return 3'd3;
      S_M4:    return 3'd4;
      S_M5:    return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic state_t next_elem(input state_t s);
    case (s)
      S_M0:    return S_M1;
      S_M1:    return S_M2;
      S_M2:    return S_M3;
      S_M3:    return S_M4;
      S_M4:    return S_M5;
      default: return S_DRAIN;
    endcase
  endfunction

  // state_q/phase_q/addr_q describe the op being issued in the current cycle.
  state_t                  state_q, state_d;
  logic                    phase_q, phase_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DRAIN_W-1:0]      drain_cnt_q, drain_cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    fail_q, fail_d;
  logic [7:0]              fail_count_q, fail_count_d;
  logic [2:0]              fail_elem_q, fail_elem_d;
  logic [ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0]   fail_data_q, fail_data_d;
  logic                    mem_write_read_q, mem_write_read_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

  logic                    pipe_vld_q  [RD_LAT];
  logic [DATA_WIDTH-1:0]   pipe_exp_q  [RD_LAT];
  logic [2:0]              pipe_elem_q [RD_LAT];
  logic [ADDR_WIDTH-1:0]   pipe_addr_q [RD_LAT];
  logic                    pipe_vld_d  [RD_LAT];
  logic [DATA_WIDTH-1:0]   pipe_exp_d  [RD_LAT];
  logic [2:0]              pipe_elem_d [RD_LAT];
  logic [ADDR_WIDTH-1:0]   pipe_addr_d [RD_LAT];

  logic accept;
  logic last_addr;
  logic mismatch;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    addr_d      = addr_q;
    drain_cnt_d = drain_cnt_q;
    accept      = 1'b0;
    last_addr   = is_down(state_q) ? (addr_q == '0) : (addr_q == LAST_ADDR);
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_M0;
          phase_d = 1'b0;
          addr_d  = '0;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == LAST_DRAIN) state_d = S_DONE;
        else                           drain_cnt_d = drain_cnt_q + 1'b1;
      end
      default: begin
        if (is_two_op(state_q) && !phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (last_addr) begin
            state_d     = next_elem(state_q);
            drain_cnt_d = '0;
            // DRAIN keeps the final address on the bus.
            if (state_d == S_DRAIN)     addr_d = addr_q;
            else if (is_down(state_d))  addr_d = LAST_ADDR;
            else                        addr_d = '0;
          end else begin
            addr_d = is_down(state_q) ? addr_q - 1'b1 : addr_q + 1'b1;
          end
        end
      end
    endcase

    mem_write_read_d = op_is_write(state_d, phase_d);
    // Write data leads its command by one cycle. Only a read in a two-op
    // element is known to be followed by a write; every other write carries
    // D0, which is zero and so coincides with the idle value.
    mem_wdata_d = (is_two_op(state_d) && !phase_d) ? wr_bg(state_d) : D0;
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d      = (state_d == S_DONE);

    // Read compare pipeline: entry emerges when its data is on mem_rdata.
    pipe_vld_d[0]  = op_is_read(state_q, phase_q);
    pipe_exp_d[0]  = rd_bg(state_q);
    pipe_elem_d[0] = elem_idx(state_q);
    pipe_addr_d[0] = addr_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_exp_d[i]  = pipe_exp_q[i-1];
      pipe_elem_d[i] = pipe_elem_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
    end
    mismatch = pipe_vld_q[RD_LAT-1] && (mem_rdata != pipe_exp_q[RD_LAT-1]);

    fail_count_d = fail_count_q;
    fail_elem_d  = fail_elem_q;
    fail_addr_d  = fail_addr_q;
    fail_data_d  = fail_data_q;
    if (accept) begin
      fail_count_d = '0;
      fail_elem_d  = '0;
      fail_addr_d  = '0;
      fail_data_d  = '0;
    end else if (mismatch) begin
      if (fail_count_q != 8'hFF) fail_count_d = fail_count_q + 8'd1;
      if (fail_count_q == 8'd0) begin
        fail_elem_d = pipe_elem_q[RD_LAT-1];
        fail_addr_d = pipe_addr_q[RD_LAT-1];
        fail_data_d = mem_rdata;
      end
    end
    fail_d = done_d && (fail_count_d != 8'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      phase_q          <= 1'b0;
      addr_q           <= '0;
      drain_cnt_q      <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      fail_q           <= 1'b0;
      fail_count_q     <= '0;
      fail_elem_q      <= '0;
      fail_addr_q      <= '0;
      fail_data_q      <= '0;
      mem_write_read_q <= 1'b0;
      mem_wdata_q      <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld_q[i]  <= 1'b0;
        pipe_exp_q[i]  <= '0;
        pipe_elem_q[i] <= '0;
        pipe_addr_q[i] <= '0;
      end
    end else begin
      state_q          <= state_d;
      phase_q          <= phase_d;
      addr_q           <= addr_d;
      drain_cnt_q      <= drain_cnt_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      fail_q           <= fail_d;
      fail_count_q     <= fail_count_d;
      fail_elem_q      <= fail_elem_d;
      fail_addr_q      <= fail_addr_d;
      fail_data_q      <= fail_data_d;
      mem_write_read_q <= mem_write_read_d;
      mem_wdata_q      <= mem_wdata_d;
      pipe_vld_q       <= pipe_vld_d;
      pipe_exp_q       <= pipe_exp_d;
      pipe_elem_q      <= pipe_elem_d;
      pipe_addr_q      <= pipe_addr_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign fail           = fail_q;
  assign fail_count     = fail_count_q;
  assign fail_elem      = fail_elem_q;
  assign fail_addr      = fail_addr_q;
  assign fail_data      = fail_data_q;
  assign mem_write_read = mem_write_read_q;
  assign mem_address    = addr_q;
  assign mem_wdata      = mem_wdata_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl
//   Bench for mbist_march_ctrl (DEPTH=8). Holds a memory with an injectable
//   stuck-at fault, an op-list reference of March C- with the expected
//   result, and a per-cycle compare process, plus literal expectations.
module tb_mbist_march_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 8;
  localparam int RD_LAT = 2;
  localparam int NOPS = 10 * DEPTH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, fail;
  logic [7:0]    fail_count;
  logic [2:0]    fail_elem;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
  logic          mem_write_read;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .fail(fail),
    .fail_count(fail_count), .fail_elem(fail_elem), .fail_addr(fail_addr),
    .fail_data(fail_data), .mem_write_read(mem_write_read), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
  endtask

  // Memory under test with an optional stuck-at fault on one address.
  logic          fault_en = 1'b0;
  logic [AW-1:0] fault_addr = '0;
  logic [DW-1:0] sa0_mask = '0;
  logic [DW-1:0] sa1_mask = '0;

  function automatic logic [DW-1:0] faulty(input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (fault_en && (a == fault_addr)) return (d & ~sa0_mask) | sa1_mask;
    return d;
  endfunction

  logic [DW-1:0] mem [16];
  logic [DW-1:0] wdata_lat, rd1, rdata_r;
  always @(posedge clk) begin
    wdata_lat <= mem_wdata;
    if (mem_write_read) mem[mem_address] <= faulty(mem_address, wdata_lat);
    rd1     <= faulty(mem_address, mem[mem_address]);
    rdata_r <= rd1;
  end
  assign mem_rdata = rdata_r;

  // Reference: the March C- op list and the result it must produce.
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [2:0]    elem;
  } op_t;
  op_t ops [NOPS];

  localparam int EL_DOWN [6] = '{0, 0, 0, 1, 1, 0};
  localparam int EL_RBG  [6] = '{0, 0, 1, 0, 1, 0};
  localparam int EL_WBG  [6] = '{0, 1, 0, 1, 0, 0};

  task automatic build_ops();
    int n;
    int a;
    n = 0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < DEPTH; i++) begin
        a = (EL_DOWN[e] != 0) ? DEPTH - 1 - i : i;
        if (e != 0) begin
          ops[n] = '{we: 1'b0, addr: AW'(a), data: (EL_RBG[e] != 0) ? '1 : '0, elem: 3'(e)};
          n++;
        end
        if (e != 5) begin
          ops[n] = '{we: 1'b1, addr: AW'(a), data: (EL_WBG[e] != 0) ? '1 : '0, elem: 3'(e)};
          n++;
        end
      end
    end
  endtask

  int            exp_count;
  int            exp_elem;
  int            exp_addr;
  logic [DW-1:0] exp_fdata;

  function automatic void compute_expected();
    logic [DW-1:0] arr [DEPTH];
    logic [DW-1:0] got;
    for (int i = 0; i < DEPTH; i++) arr[i] = '0;
    exp_count = 0; exp_elem = 0; exp_addr = 0; exp_fdata = '0;
    for (int i = 0; i < NOPS; i++) begin
      if (ops[i].we) begin
        arr[ops[i].addr] = faulty(ops[i].addr, ops[i].data);
      end else begin
        got = faulty(ops[i].addr, arr[ops[i].addr]);
        if (got != ops[i].data) begin
          if (exp_count == 0) begin
            exp_elem = int'(ops[i].elem); exp_addr = int'(ops[i].addr); exp_fdata = got;
          end
          if (exp_count < 255) exp_count++;
        end
      end
    end
  endfunction

  // Per-cycle compare process; k counts cycles since the start-accept cycle.
  int            k = 0;
  bit            active = 0;
  bit            in_done = 0;
  int            done_k = 0;
  logic [AW-1:0] log_addr [128];
  logic          log_wr [128];
  logic [DW-1:0] log_wdata [128];
  logic [DW-1:0] nxt;

  always @(posedge clk) begin
    if (!rst_n) begin
      active = 0; in_done = 0;
    end else if (start && !active) begin
      active = 1; in_done = 0; k = 1; compute_expected();
    end else if (active) begin
      k++;
    end
    #1;
    if (rst_n) begin
      if (active) begin
        if (k < 128) begin
          log_addr[k] = mem_address; log_wr[k] = mem_write_read; log_wdata[k] = mem_wdata;
        end
        if (k <= NOPS) begin
          check("busy_run", busy, 1);
          check("done_run", done, 0);
          check("op_kind", mem_write_read, ops[k-1].we);
          check("op_addr", mem_address, ops[k-1].addr);
          nxt = '0;
          if (k < NOPS && ops[k].we) nxt = ops[k].data;
          check("wdata_lead", mem_wdata, nxt);
          if (k == 1) begin
            check("clr_fail", fail, 0);
            check("clr_count", fail_count, 0);
            check("clr_elem", fail_elem, 0);
            check("clr_addr", fail_addr, 0);
            check("clr_data", fail_data, 0);
          end
        end else if (k <= NOPS + RD_LAT) begin
          check("busy_drain", busy, 1);
          check("done_drain", done, 0);
          check("drain_read", mem_write_read, 0);
          check("drain_addr", mem_address, ops[NOPS-1].addr);
          check("drain_wdata", mem_wdata, 0);
        end else begin
          done_k = k; active = 0; in_done = 1;
        end
      end
      if (!active && in_done) begin
        check("busy_done", busy, 0);
        check("done_flag", done, 1);
        check("fail_flag", fail, exp_count != 0);
        check("fail_count", fail_count, exp_count);
        check("fail_elem", fail_elem, exp_elem);
        check("fail_addr", fail_addr, exp_addr);
        check("fail_data", fail_data, exp_fdata);
        check("done_wdata", mem_wdata, 0);
        check("done_read", mem_write_read, 0);
      end else if (!active) begin
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_fail", fail, 0);
        check("idle_count", fail_count, 0);
        check("idle_wr", mem_write_read, 0);
        check("idle_addr", mem_address, 0);
        check("idle_wdata", mem_wdata, 0);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk); n++;
    end
    check("done_within_bound", done, 1);
    @(negedge clk);
  endtask

  task automatic reset_values(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_fail"}, fail, 0);
    check({tag, "_count"}, fail_count, 0);
    check({tag, "_faddr"}, fail_addr, 0);
    check({tag, "_wr"}, mem_write_read, 0);
    check({tag, "_addr"}, mem_address, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    build_ops();
    for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
    repeat (3) @(negedge clk);
    reset_values("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fault-free run with literal timing and sequence pins.
    pulse_start();
    wait_done();
    check("lit_done_cycle", done_k, 83);
    check("lit_pass", fail, 0);
    check("lit_pass_count", fail_count, 0);
    check("lit_m3_addr41", log_addr[41], 7);
    check("lit_m3_rd41", log_wr[41], 0);
    check("lit_m3_wr42", log_wr[42], 1);
    check("lit_m3_addr42", log_addr[42], 7);
    check("lit_m3_addr56", log_addr[56], 0);
    check("lit_wdata41", log_wdata[41], 8'hFF);
    check("lit_m0_addr1", log_addr[1], 0);
    check("lit_m5_addr80", log_addr[80], 7);

    // Bit 1 of address 3 stuck at 0.
    fault_en = 1'b1; fault_addr = 4'd3; sa0_mask = 8'h02; sa1_mask = 8'h00;
    pulse_start();
    wait_done();
    check("lit_sa0_fail", fail, 1);
    check("lit_sa0_elem", fail_elem, 2);
    check("lit_sa0_addr", fail_addr, 3);
    check("lit_sa0_data", fail_data, 8'hFD);
    check("lit_sa0_count", fail_count, 2);

    // Back-to-back from DONE with the fault removed.
    fault_en = 1'b0;
    pulse_start();
    check("lit_b2b_clr_fail", fail, 0);
    check("lit_b2b_clr_count", fail_count, 0);
    check("lit_b2b_clr_data", fail_data, 0);
    wait_done();
    check("lit_b2b_pass", fail, 0);

    // Reset in the middle of a run.
    pulse_start();
    repeat (29) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 reset_values("midrst");
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    pulse_start();
    wait_done();
    check("lit_after_rst_cycle", done_k, 83);
    check("lit_after_rst_pass", fail, 0);

    // start while busy is ignored.
    pulse_start();
    repeat (8) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (39) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done();
    check("lit_restart_cycle", done_k, 83);

    // Randomized faults and stray start pulses.
    for (int r = 0; r < 8; r++) begin
      fault_en   = ($urandom_range(0, 3) != 0);
      fault_addr = AW'($urandom_range(0, DEPTH - 1));
      sa0_mask   = DW'($urandom);
      sa1_mask   = DW'($urandom) & ~sa0_mask;
      pulse_start();
      n = $urandom_range(2, 75);
      repeat (n) @(negedge clk);
      start = 1'b1; @(negedge clk); start = 1'b0;
      wait_done();
      check("rand_done_cycle", done_k, 83);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mbist_march_ctrl.md
Name: mbist_march_ctrl

Overview:
- Memory BIST controller that runs the March C- algorithm against the single-port fault_mem-style array.
- Drives write_read/address/wdata and compares returned rdata against expected values.
- Reports pass/fail plus first-failure diagnostics.
- Sits between the test-mode top level (start/done/result) and the memory under test.

Parameters:
DATA_WIDTH, 8, memory word width
ADDR_WIDTH, 4, memory address width
DEPTH, 16, number of addresses tested (0..DEPTH-1), DEPTH <= 2**ADDR_WIDTH
RD_LAT, 2, cycles from read issue to valid mem_rdata (memory registers twice)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a test run
busy  out  1  high while a run is in progress
done  out  1  high from run completion until next accepted start or reset
fail  out  1  valid with done; 1 = at least one miscompare
fail_count  out  8  number of miscompares, saturates at 255
fail_elem  out  3  March element index (0..5) of first miscompare
fail_addr  out  ADDR_WIDTH  address of first miscompare
fail_data  out  DATA_WIDTH  read data of first miscompare
mem_write_read  out  1  1 = write, 0 = read
mem_address  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  write data, one cycle ahead of its write command
mem_rdata  in  DATA_WIDTH  memory read data

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, fail=0, fail_count=0, fail_elem=0, fail_addr=0, fail_data=0, mem_write_read=0, mem_address=0, mem_wdata=0; compare pipeline cleared. Reset mid-run aborts immediately with no report.
- Background: D0 = all zeros, D1 = all ones.
- Elements:
  - M0 up(w0)
  - M1 up(r0,w1)
  - M2 up(r1,w0)
  - M3 down(r0,w1)
  - M4 down(r1,w0)
  - M5 up(r0)
- "up" addresses run 0..DEPTH-1; "down" runs DEPTH-1..0.
- States: IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE.
  - Two-op elements alternate a phase bit (read, then write to the same address). The address advances after the write.
  - The element advances after its last address; there are no idle cycles between elements.
- One memory op per cycle. Total ops = 10*DEPTH.
- start is sampled in IDLE or DONE. The first op is issued the next cycle. busy rises with the first op and stays high through DRAIN.
- start while busy is ignored.
- Write data lead: the memory captures wdata one cycle before it commits the write. So mem_wdata in cycle t equals the data of the write issued in cycle t+1. mem_wdata is 0 when no write follows.
  - For M0 this means D0 is presented in the start-accept cycle.
- Read compare: each read pushes {expected, element, address} into an RD_LAT-deep shift pipeline. mem_rdata is compared when the entry emerges.
  - On mismatch, fail_count increments (saturating at 255).
  - The first mismatch only latches fail_elem, fail_addr and fail_data; later mismatches do not overwrite them.
  - The run continues to completion regardless of failures.
- DRAIN lasts RD_LAT cycles, with mem_write_read=0 and mem_address held. Then DONE: busy=0, done=1, fail = (fail_count!=0).
- Accepting start from DONE clears done, fail, fail_count and the fail_* outputs in the same edge.
- Cycle count: done is first high exactly 10*DEPTH + RD_LAT + 1 cycles after the cycle in which start was sampled.
- Width rules: address counters are ADDR_WIDTH bits. The down count terminates on reaching 0 without wrapping; the up count terminates at DEPTH-1.

Test Plan:
- Fault-free memory, DEPTH=8, DATA_WIDTH=8: pulse start -> exactly 80 ops; done high 83 cycles after start; fail=0, fail_count=0.
- Bit 1 of address 3 stuck-at-0:
  - Required result -> fail=1, fail_elem=2, fail_addr=3, fail_data=0xFD.
  - Expected fail_count: 2. M2 r1 and M4 r1 fail; the r0 reads still read 0.
- Address/sequence check, DEPTH=8: monitor mem_address. M3 starts at address 7 with a read at cycle 41, write at 42, and reaches address 0 at cycle 56. mem_wdata=0xFF in cycle 41 for the write in cycle 42.
- rst_n pulsed low at cycle 30 of a run -> all outputs at reset values immediately. Next start gives a full clean 80-op run with pass.
- start re-pulsed at cycles 10 and 50 of a run -> ignored; single run, done at cycle 83.
- Back-to-back runs: first run on a faulty memory (fail=1), then start from DONE with the fault removed -> fail_* cleared at accept, second run reports fail=0.
